// File: rtl/mc_controller.sv
// mc_controller: multicycle CPU control FSM.
//
// Sequences every instruction through FETCH / DECODE / execute-class states /
// memory / writeback, one state per clock, and decodes the datapath controls
// from the current state. Memory states stall on mem_ready.
//
// Handshake: mem_req is held high (with iord/memwrite stable) from the first
// cycle of an access until the cycle in which mem_ready=1; the access
// completes on that cycle's rising edge and the request drops after it.
// mem_ready is ignored whenever mem_req is low.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset (all outputs forced to 0)
//   op         instr[31:26] from the instruction register
//   zero       ALU zero flag (branch decision)
//   mem_ready  memory completes the current access this cycle
//   mem_req, memwrite, irwrite, iord, alusrca, alusrcb, aluop, pcsrc,
//   regdst, memtoreg, regwrite, pcen  datapath controls
//   illegal    one-cycle pulse in DECODE on an unsupported opcode
//   state_dbg  current FSM state encoding, for observation only
module mc_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       pcen,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t state;
  logic   pcwrite;
  logic   branch;

  assign state_dbg = state;

  // State register and transitions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:   if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXECUTE;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADDI:      state <= S_ADDIEX;
            OP_J:         state <= S_JUMP;
            default:      state <= S_FETCH;
          endcase
        end
        // IR is not reloaded until the next FETCH, so op is still the
        // instruction that was dispatched from DECODE.
        S_MEMADR:  state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   if (mem_ready) state <= S_MEMWB;
        S_MEMWR:   if (mem_ready) state <= S_FETCH;
        S_EXECUTE: state <= S_ALUWB;
        S_ADDIEX:  state <= S_ADDIWB;
        default:   state <= S_FETCH;  // writebacks, BRANCH, JUMP, unused codes
      endcase
    end
  end

  // Control decode. Gated by reset_n so that every output, including the
  // FETCH-state mem_req, is low for as long as reset is held.
  always_comb begin
    mem_req  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    iord     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsrc    = 2'b00;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    illegal  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    if (reset_n) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          alusrcb = 2'b01;
          // PC+4 and the IR load commit only on the completing cycle.
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        S_DECODE: begin
          alusrcb = 2'b11;
          case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
            default:                                       illegal = 1'b1;
          endcase
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        S_MEMWR: begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_EXECUTE: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        S_ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        S_BRANCH: begin
          alusrca = 1'b1;
          aluop   = 2'b01;
          pcsrc   = 2'b01;
          branch  = 1'b1;
        end
        S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_ADDIWB: begin
          regwrite = 1'b1;
        end
        S_JUMP: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

  assign pcen = pcwrite | (branch & zero);

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller. Each cycle's inputs and the expected control word
// come from a vector table; expected words go through a queue and are
// compared against the observed word half a cycle before the next edge.
module tb_mc_controller;

  logic       clk;
  logic       reset_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, memwrite, irwrite, iord, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       regdst, memtoreg, regwrite, pcen, illegal;
  logic [3:0] state_dbg;

  mc_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .irwrite(irwrite), .iord(iord),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .pcen(pcen),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  // Word layout: {state, mem_req, memwrite, irwrite, iord, alusrca,
  //               alusrcb[1:0], aluop[1:0], pcsrc[1:0],
  //               regdst, memtoreg, regwrite, pcen, illegal}
  localparam logic [19:0] W_RST   = 20'h0;
  localparam logic [19:0] W_F_R   = {4'd0, 1'b1,1'b0,1'b1,1'b0,1'b0, 2'b01,2'b00,2'b00, 1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [19:0] W_F_N   = {4'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b00,2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [19:0] W_DEC   = {4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11,2'b00,2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [19:0] W_DEC_I = {4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11,2'b00,2'b00, 1'b0,1'b0,1'b0,1'b0,1'b1};
  localparam logic [19:0] W_MADR  = {4'd2, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10,2'b00,2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [19:0] W_MRD   = {4'd3, 1'b1,1'b0,1'b0,1'b1,1'b0, 2'b00,2'b00,2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [19:0] W_MWB   = {4'd4, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00, 1'b0,1'b1,1'b1,1'b0,1'b0};
  localparam logic [19:0] W_MWR   = {4'd5, 1'b1,1'b1,1'b0,1'b1,1'b0, 2'b00,2'b00,2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [19:0] W_EXE   = {4'd6, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b10,2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [19:0] W_AWB   = {4'd7, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00, 1'b1,1'b0,1'b1,1'b0,1'b0};
  localparam logic [19:0] W_BR1   = {4'd8, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b01,2'b01, 1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [19:0] W_BR0   = {4'd8, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b01,2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [19:0] W_AEX   = {4'd9, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10,2'b00,2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [19:0] W_IWB   = {4'd10,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00, 1'b0,1'b0,1'b1,1'b0,1'b0};
  localparam logic [19:0] W_JMP   = {4'd11,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b10, 1'b0,1'b0,1'b0,1'b1,1'b0};

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        op_any;   // op is irrelevant in this cycle: drive random
    logic        zero;
    logic        rdy;
    logic [19:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [19:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  function automatic logic [19:0] observed();
    return {state_dbg, mem_req, memwrite, irwrite, iord, alusrca,
            alusrcb, aluop, pcsrc, regdst, memtoreg, regwrite, pcen, illegal};
  endfunction

  task automatic add(input string nm, input logic [5:0] o, input logic any,
                     input logic z, input logic r, input logic [19:0] e);
    vec_t v;
    v.name = nm; v.op = o; v.op_any = any; v.zero = z; v.rdy = r; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm);
    logic [19:0] got;
    logic [19:0] e;
    got = observed();
    if (exp_q.size() == 0) begin
      bad++;
      total++;
      $display("FAIL %s: scoreboard empty, got=%h", nm, got);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s: got=%05h want=%05h", nm, got, e);
      end
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then compare.
  task automatic step(input string nm, input logic [5:0] o, input logic z,
                      input logic r, input logic [19:0] e);
    @(negedge clk);
    op = o; zero = z; mem_ready = r;
    exp_q.push_back(e);
    #1;
    check(nm);
  endtask

  initial begin
    reset_n = 1'b0; op = 6'd0; zero = 1'b0; mem_ready = 1'b0;

    // reset state
    #3;
    exp_q.push_back(W_RST);
    check("reset_hold");
    @(posedge clk);
    #2 reset_n = 1'b1;

    // lw, zero wait
    add("lw_fetch",  LW, 1, 0, 1, W_F_R);
    add("lw_decode", LW, 0, 0, 1, W_DEC);
    add("lw_memadr", LW, 0, 0, 1, W_MADR);
    add("lw_memrd",  LW, 1, 0, 1, W_MRD);
    add("lw_memwb",  LW, 1, 0, 0, W_MWB);
    // sw, two stall cycles in MEMWR
    add("sw_fetch",  SW, 1, 0, 1, W_F_R);
    add("sw_decode", SW, 0, 0, 0, W_DEC);
    add("sw_memadr", SW, 0, 0, 0, W_MADR);
    add("sw_memwr0", SW, 1, 0, 0, W_MWR);
    add("sw_memwr1", SW, 1, 0, 0, W_MWR);
    add("sw_memwr2", SW, 1, 0, 1, W_MWR);
    // beq taken / not taken
    add("beq1_fetch",  BEQ, 1, 0, 1, W_F_R);
    add("beq1_decode", BEQ, 0, 0, 1, W_DEC);
    add("beq1_branch", BEQ, 1, 1, 1, W_BR1);
    add("beq0_fetch",  BEQ, 1, 1, 1, W_F_R);
    add("beq0_decode", BEQ, 0, 1, 1, W_DEC);
    add("beq0_branch", BEQ, 1, 0, 1, W_BR0);
    // R-type with two fetch stalls
    add("rt_fetch_s0", RT, 1, 0, 0, W_F_N);
    add("rt_fetch_s1", RT, 1, 0, 0, W_F_N);
    add("rt_fetch",    RT, 1, 0, 1, W_F_R);
    add("rt_decode",   RT, 0, 0, 0, W_DEC);
    add("rt_execute",  RT, 1, 1, 0, W_EXE);
    add("rt_aluwb",    RT, 1, 0, 1, W_AWB);
    // addi
    add("addi_fetch",  ADDI, 1, 0, 1, W_F_R);
    add("addi_decode", ADDI, 0, 0, 1, W_DEC);
    add("addi_ex",     ADDI, 1, 0, 0, W_AEX);
    add("addi_wb",     ADDI, 1, 0, 1, W_IWB);
    // jump
    add("j_fetch",  J, 1, 0, 1, W_F_R);
    add("j_decode", J, 0, 0, 0, W_DEC);
    add("j_jump",   J, 1, 0, 0, W_JMP);
    // illegal opcode
    add("ill_fetch",  BAD, 1, 0, 1, W_F_R);
    add("ill_decode", BAD, 0, 0, 1, W_DEC_I);
    add("ill_next",   BAD, 0, 0, 0, W_F_N);

    for (int i = 0; i < vecs.size(); i++) begin
      logic [5:0] o;
      o = vecs[i].op_any ? 6'($urandom_range(0, 63)) : vecs[i].op;
      step(vecs[i].name, o, vecs[i].zero, vecs[i].rdy, vecs[i].exp);
    end

    // Reset asserted mid-lw while MEMRD is stalled.
    step("rst_fetch",  LW, 0, 1, W_F_R);
    step("rst_decode", LW, 0, 1, W_DEC);
    step("rst_memadr", LW, 0, 1, W_MADR);
    step("rst_memrd",  LW, 0, 0, W_MRD);
    @(negedge clk);
    reset_n = 1'b0;
    mem_ready = 1'b1;
    exp_q.push_back(W_RST);
    #1;
    check("rst_async_zero");
    step("rst_held", LW, 0, 1, W_RST);  // no MEMWB across the edge
    @(posedge clk);
    #2 reset_n = 1'b1;
    step("rel_fetch_n", LW, 0, 0, W_F_N);
    step("rel_fetch_r", LW, 0, 1, W_F_R);
    step("rel_decode",  SW, 0, 1, W_DEC);
    step("rel_memadr",  SW, 0, 1, W_MADR);
    step("rel_memwr",   SW, 0, 1, W_MWR);
    step("rel_back",    SW, 0, 0, W_F_N);

    if (exp_q.size() != 0) begin
      bad++;
      total++;
      $display("FAIL scoreboard_drain: left=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control FSM for the CPU. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the datapath mux selects, write enables and the 2-bit `aluop` consumed by the ALU decoder, which combines it with `funct`. Stalls on a ready/request handshake with the unified instruction/data memory.

## Interface
Parameters: none (opcode encodings fixed to MIPS-I).

- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `op`  in  6  opcode field of the instruction register (`instr[31:26]`)
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_req`  out  1  memory access request
- `memwrite`  out  1  memory write strobe
- `irwrite`  out  1  instruction register load
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = register A
- `alusrcb`  out  2  ALU B select: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- `aluop`  out  2  00 = add, 01 = sub, 10 = use funct
- `pcsrc`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `regdst`  out  1  write register: 0 = rt, 1 = rd
- `memtoreg`  out  1  writeback data: 0 = ALUOut, 1 = memory data
- `regwrite`  out  1  register file write
- `pcen`  out  1  PC load = `pcwrite | (branch & zero)`
- `illegal`  out  1  one-cycle pulse in DECODE on an unsupported opcode

## Operation
- State is a 4-bit register. Reset sets it to FETCH.
- While `reset_n` is low, every output is 0. This includes `mem_req`.
- Outputs are decoded combinationally from state. Any output not listed below is 0 in that state.
  - FETCH: `mem_req`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsrc`=00. `irwrite`=`pcwrite`=`mem_ready`.
  - DECODE: `alusrcb`=11, `aluop`=00.
  - MEMADR: `alusrca`=1, `alusrcb`=10.
  - MEMRD: `mem_req`=1, `iord`=1.
  - MEMWB: `memtoreg`=1, `regwrite`=1.
  - MEMWR: `mem_req`=1, `iord`=1, `memwrite`=1.
  - EXECUTE: `alusrca`=1, `alusrcb`=00, `aluop`=10.
  - ALUWB: `regdst`=1, `regwrite`=1.
  - BRANCH: `alusrca`=1, `aluop`=01, `pcsrc`=01, `branch`=1.
  - ADDIEX: `alusrca`=1, `alusrcb`=10.
  - ADDIWB: `regwrite`=1.
  - JUMP: `pcsrc`=10, `pcwrite`=1.
- Transitions:
  - FETCH→DECODE when `mem_ready`, else hold.
  - DECODE dispatches on `op`:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 → EXECUTE
    - 000100 → BRANCH
    - 001000 → ADDIEX
    - 000010 → JUMP
    - any other → FETCH, with `illegal`=1 for that cycle
  - MEMADR: lw → MEMRD, sw → MEMWR. Decided by `op`, which is stable because the IR is unchanged.
  - MEMRD→MEMWB when `mem_ready`, else hold.
  - MEMWR→FETCH when `mem_ready`, else hold.
  - EXECUTE→ALUWB. ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP → FETCH.
  - Unused state encodings → FETCH.
- `pcen` = `pcwrite | (branch & zero)`. It is only asserted in FETCH (when `mem_ready`), BRANCH (when `zero`) and JUMP.

## Timing
- One state per clock. There is no memory wait when `mem_ready` is tied high.
- Cycles per instruction with zero wait: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle that `mem_ready` is low in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs are held constant during the stall.
- `mem_req`, `iord` and `memwrite` stay stable from the first cycle of the request until the cycle in which `mem_ready`=1. The request drops on the following edge.
- `mem_ready` is ignored in states that do not request memory.
- `op` is sampled only in DECODE and MEMADR. Changes in other states have no effect.
- If `reset_n` is asserted mid-instruction, the FSM returns to FETCH asynchronously. Outputs go to 0 immediately, and no partial writeback occurs after reset.
- On release, FETCH outputs appear in the same cycle. The first transition is on the first rising edge with `reset_n` high and `mem_ready`=1.

## Test plan
- lw, `mem_ready`=1: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. `regwrite`=`memtoreg`=1 only in cycle 5. `pcen`=1 only in cycle 1.
- sw with `mem_ready` low for 2 cycles in MEMWR: `memwrite`=`iord`=`mem_req`=1 for 3 consecutive cycles, then FETCH. `regwrite` is never asserted.
- beq run twice, with `zero`=1 and then `zero`=0: `aluop`=01 and `pcsrc`=01 in cycle 3. `pcen`=1 in that cycle for the first run and 0 for the second.
- R-type and addi: `aluop`=10 in EXECUTE with `regdst`=1 in ALUWB. `alusrcb`=10, `aluop`=00 in ADDIEX with `regdst`=0 in ADDIWB. Each takes 4 cycles.
- Opcode 111111: `illegal` pulses exactly once, in DECODE. The next state is FETCH, and no write enable is asserted.
- Reset asserted in MEMRD with `mem_ready`=0: all outputs are 0 immediately. After release, FETCH is presented with `mem_req`=1, and `irwrite` follows `mem_ready`.
